mem_march_ctrl: RTL and testbench

- Built-in self-test sequencer and port arbiter for the DFFRAM-backed Wishbone memory.
- Sits between the Wishbone-facing memory front end and the RAM macro port (ena / byte-wen / addr / wdata / rdata).
- When idle, the host path passes straight through. When started, it runs a March C- test over every word and reports pass/fail plus the first failing location.

---
 rtl/mem_march_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_march_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_march_ctrl.sv
// March C- self-test sequencer and RAM port arbiter for the DFFRAM-backed
// Wishbone memory. When idle the host path reaches the RAM macro directly.
// When started, the controller runs
//   w0 ; up(r0,w1) ; up(r1,w0) ; down(r0,w1) ; down(r1,w0) ; up(r0)
// over every word and records pass/fail, a saturating mismatch count and the
// first failing location.
module mem_march_ctrl #(
    parameter int ADR_WIDTH = 8,
    parameter int ERR_W     = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [31:0]          bg_i,
    input  logic                 h_ena_i,
    input  logic [3:0]           h_wen_i,
    input  logic [ADR_WIDTH-1:0] h_addr_i,
    input  logic [31:0]          h_wdata_i,
    output logic                 h_gnt_o,
    output logic                 ram_ena_o,
    output logic [3:0]           ram_wen_o,
    output logic [ADR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]          ram_wdata_o,
    input  logic [31:0]          ram_rdata_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 fail_o,
    output logic [ERR_W-1:0]     err_cnt_o,
    output logic [ADR_WIDTH-1:0] fail_addr_o,
    output logic [31:0]          fail_exp_o,
    output logic [31:0]          fail_act_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_M0,
        S_M1,
        S_M2,
        S_M3,
        S_M4,
        S_M5,
        S_DONE
    } state_t;

    localparam logic [ADR_WIDTH-1:0] ADDR_LAST = '1;

    state_t                 state;
    logic                   phase;      // 0: read cycle, 1: write/compare cycle
    logic [ADR_WIDTH-1:0]   addr;
    logic [31:0]            bg;

    logic                   bist_ena;
    logic [3:0]             bist_wen;
    logic [31:0]            bist_wdata;
    logic                   cmp_en;
    logic [31:0]            exp_word;
    logic                   mismatch;
    logic                   count_down;
    logic                   addr_end;

    // Decode the current march element and phase into RAM strobes and the compare target.
    always_comb begin
        bist_ena   = 1'b0;
        bist_wen   = '0;
        bist_wdata = '0;
        cmp_en     = 1'b0;
        exp_word   = bg;
        count_down = (state == S_M3) || (state == S_M4);
        addr_end   = count_down ? (addr == '0) : (addr == ADDR_LAST);
        case (state)
            S_M0: begin
                bist_ena   = 1'b1;
                bist_wen   = '1;
                bist_wdata = bg;
            end
            S_M1, S_M3: begin
                bist_ena = 1'b1;
                exp_word = bg;
                if (phase) begin
                    bist_wen   = '1;
                    bist_wdata = ~bg;
                    cmp_en     = 1'b1;
                end
            end
            S_M2, S_M4: begin
                bist_ena = 1'b1;
                exp_word = ~bg;
                if (phase) begin
                    bist_wen   = '1;
                    bist_wdata = bg;
                    cmp_en     = 1'b1;
                end
            end
            S_M5: begin
                // Final r0 pass: the second cycle only compares, the RAM is left idle.
                bist_ena = !phase;
                exp_word = bg;
                cmp_en   = phase;
            end
            default: ;
        endcase
        mismatch = cmp_en && (ram_rdata_i != exp_word);
    end

    // RAM port mux: host passes straight through unless the test owns the port.
    always_comb begin
        if (busy_o) begin
            ram_ena_o   = bist_ena;
            ram_wen_o   = bist_wen;
            ram_addr_o  = addr;
            ram_wdata_o = bist_wdata;
        end else begin
            ram_ena_o   = h_ena_i;
            ram_wen_o   = h_wen_i;
            ram_addr_o  = h_addr_i;
            ram_wdata_o = h_wdata_i;
        end
    end

    assign h_gnt_o = !busy_o;

    // March sequencer with registered status and error capture.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= S_IDLE;
            phase       <= 1'b0;
            addr        <= '0;
            bg          <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            fail_o      <= 1'b0;
            err_cnt_o   <= '0;
            fail_addr_o <= '0;
            fail_exp_o  <= '0;
            fail_act_o  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        bg          <= bg_i;
                        done_o      <= 1'b0;
                        fail_o      <= 1'b0;
                        err_cnt_o   <= '0;
                        fail_addr_o <= '0;
                        fail_exp_o  <= '0;
                        fail_act_o  <= '0;
                        addr        <= '0;
                        phase       <= 1'b0;
                        busy_o      <= 1'b1;
                        state       <= S_M0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    if (abort_i) begin
                        // The RAM access of this cycle still happens; its compare is dropped.
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                        phase  <= 1'b0;
                        addr   <= '0;
                    end else begin
                        if (mismatch) begin
                            if (err_cnt_o != '1) begin
                                err_cnt_o <= err_cnt_o + 1'b1;
                            end
                            fail_o <= 1'b1;
                            if (!fail_o) begin
                                fail_addr_o <= addr;
                                fail_exp_o  <= exp_word;
                                fail_act_o  <= ram_rdata_i;
                            end
                        end
                        if ((state == S_M0) || phase) begin
                            phase <= 1'b0;
                            if (addr_end) begin
                                case (state)
                                    S_M0: begin
                                        state <= S_M1;
                                        addr  <= '0;
                                    end
                                    S_M1: begin
                                        state <= S_M2;
                                        addr  <= '0;
                                    end
                                    S_M2: begin
                                        state <= S_M3;
                                        addr  <= ADDR_LAST;
                                    end
                                    S_M3: begin
                                        state <= S_M4;
                                        addr  <= ADDR_LAST;
                                    end
                                    S_M4: begin
                                        state <= S_M5;
                                        addr  <= '0;
                                    end
                                    default: begin
                                        state  <= S_DONE;
                                        addr   <= '0;
                                        busy_o <= 1'b0;
                                        done_o <= 1'b1;
                                    end
                                endcase
                            end else if (count_down) begin
                                addr <= addr - 1'b1;
                            end else begin
                                addr <= addr + 1'b1;
                            end
                        end else begin
                            phase <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_march_ctrl.sv
// Bench for mem_march_ctrl: RAM model with injectable stuck-at faults,
// table-driven host pass-through vectors, randomized march runs checked
// against an array-level March C- model, and hand-written abort/reset sequences.
module tb_mem_march_ctrl;

    localparam int AW = 8;
    localparam int D  = 256;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [31:0]   bg_i = '0;
    logic          h_ena_i = 1'b0;
    logic [3:0]    h_wen_i = '0;
    logic [AW-1:0] h_addr_i = '0;
    logic [31:0]   h_wdata_i = '0;
    logic          h_gnt_o;
    logic          ram_ena_o;
    logic [3:0]    ram_wen_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_wdata_o;
    logic [31:0]   ram_rdata;
    logic          busy_o;
    logic          done_o;
    logic          fail_o;
    logic [EW-1:0] err_cnt_o;
    logic [AW-1:0] fail_addr_o;
    logic [31:0]   fail_exp_o;
    logic [31:0]   fail_act_o;

    always #5 clk = ~clk;

    mem_march_ctrl #(.ADR_WIDTH(AW), .ERR_W(EW)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
        .bg_i(bg_i), .h_ena_i(h_ena_i), .h_wen_i(h_wen_i), .h_addr_i(h_addr_i),
        .h_wdata_i(h_wdata_i), .h_gnt_o(h_gnt_o), .ram_ena_o(ram_ena_o),
        .ram_wen_o(ram_wen_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata), .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
        .err_cnt_o(err_cnt_o), .fail_addr_o(fail_addr_o), .fail_exp_o(fail_exp_o),
        .fail_act_o(fail_act_o)
    );

    // RAM model: stores raw data, faults are applied on the read path.
    logic [31:0] mem [D];
    bit          fault_all = 1'b0;
    int          fault_addr = -1;
    logic [31:0] s1 = '0;
    logic [31:0] s0 = '0;

    function automatic logic [31:0] faulty(input int a, input logic [31:0] d);
        if (fault_all || a == fault_addr) return (d | s1) & ~s0;
        return d;
    endfunction

    always @(posedge clk) begin
        if (ram_ena_o) begin
            ram_rdata <= faulty(int'(ram_addr_o), mem[ram_addr_o]);
            for (int b = 0; b < 4; b++)
                if (ram_wen_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Expected BIST port activity for busy cycle i (0-based), derived from the element list.
    logic [31:0] cur_bg = '0;
    int          idx = 0;
    int          trace_err = 0;

    function automatic logic op_ok(input int i, input logic [31:0] bg);
        int j, e, k, s, a;
        logic ena;
        logic [3:0] wen;
        logic [31:0] wd;
        if (h_gnt_o !== 1'b0) return 1'b0;
        if (i < D) begin
            ena = 1'b1; wen = 4'hF; a = i; wd = bg;
        end else begin
            j = i - D;
            e = j / (2*D) + 1;
            k = j % (2*D);
            s = k / 2;
            if (e > 5) return 1'b0;
            a = (e == 3 || e == 4) ? D - 1 - s : s;
            if (k % 2 == 0) begin
                ena = 1'b1; wen = 4'h0; wd = '0;
            end else if (e == 5) begin
                ena = 1'b0; wen = 4'h0; wd = '0;
            end else begin
                ena = 1'b1; wen = 4'hF; wd = (e == 1 || e == 3) ? ~bg : bg;
            end
        end
        if (ram_ena_o !== ena || ram_wen_o !== wen) return 1'b0;
        if (ena && ram_addr_o !== a[AW-1:0]) return 1'b0;
        if (wen != 4'h0 && ram_wdata_o !== wd) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (busy_o === 1'b1) begin
            if (!op_ok(idx, cur_bg)) begin
                trace_err <= trace_err + 1;
                if (trace_err < 3) $display("trace diff at busy cycle %0d", idx + 1);
            end
            idx <= idx + 1;
        end else begin
            idx <= 0;
        end
    end

    // Array-level March C- reference with the same fault applied on reads.
    function automatic void ref_march(input logic [31:0] bg, output int errs,
                                      output logic [AW-1:0] faddr,
                                      output logic [31:0] fexp, output logic [31:0] fact);
        logic [31:0] m [D];
        logic [31:0] rd, rexp, wval;
        int a;
        errs = 0; faddr = '0; fexp = '0; fact = '0;
        for (int i = 0; i < D; i++) m[i] = bg;
        for (int e = 1; e <= 5; e++) begin
            rexp = (e == 2 || e == 4) ? ~bg : bg;
            wval = (e == 1 || e == 3) ? ~bg : bg;
            for (int s = 0; s < D; s++) begin
                a = (e == 3 || e == 4) ? D - 1 - s : s;
                rd = faulty(a, m[a]);
                if (rd != rexp) begin
                    if (errs == 0) begin
                        faddr = a[AW-1:0]; fexp = rexp; fact = rd;
                    end
                    errs++;
                end
                if (e != 5) m[a] = wval;
            end
        end
        if (errs > 255) errs = 255;
    endfunction

    task automatic do_start(input logic [31:0] bg, input logic with_abort);
        @(posedge clk); #1;
        bg_i = bg; start_i = 1'b1; abort_i = with_abort; cur_bg = bg;
        @(posedge clk); #1;
        start_i = 1'b0; abort_i = 1'b0; bg_i = $urandom;
    endtask

    // Counts busy cycles (bounded), scribbling on the host port meanwhile.
    task automatic count_busy(input int poke_at, input int abort_at, output int n);
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (busy_o !== 1'b1) break;
            n++;
            @(posedge clk); #1;
            h_ena_i = 1'($urandom); h_wen_i = 4'($urandom);
            h_addr_i = AW'($urandom); h_wdata_i = $urandom;
            start_i = (n + 1 == poke_at);
            abort_i = (n + 1 == abort_at);
            bg_i = $urandom;
        end
        start_i = 1'b0; abort_i = 1'b0;
        h_ena_i = 1'b0; h_wen_i = '0; h_addr_i = '0; h_wdata_i = '0;
    endtask

    task automatic check_run(input string tag, input int n, input int exp_n, input logic exp_done,
                             input int exp_err, input logic [AW-1:0] fa,
                             input logic [31:0] fe, input logic [31:0] fx);
        check({tag, " busy_len"}, n, exp_n);
        check({tag, " busy"}, busy_o, 1'b0);
        check({tag, " gnt"}, h_gnt_o, 1'b1);
        check({tag, " done"}, done_o, exp_done);
        check({tag, " fail"}, fail_o, exp_err != 0);
        check({tag, " err_cnt"}, err_cnt_o, exp_err);
        check({tag, " fail_addr"}, fail_addr_o, fa);
        check({tag, " fail_exp"}, fail_exp_o, fe);
        check({tag, " fail_act"}, fail_act_o, fx);
        check({tag, " trace_errs"}, trace_err, 0);
    endtask

    typedef struct {
        logic          ena;
        logic [3:0]    wen;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          exp_gnt;
        logic          exp_ena;
        logic [3:0]    exp_wen;
        logic [AW-1:0] exp_addr;
        logic [31:0]   exp_wdata;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int n, errs;
        logic [AW-1:0] faddr;
        logic [31:0] fexp, fact;
        logic [36+AW:0] got, want;

        vt[0] = '{1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF};
        vt[1] = '{1'b1, 4'h2, 8'h10, 32'h0000AB00, 1'b1, 1'b1, 4'h2, 8'h10, 32'h0000AB00};
        vt[2] = '{1'b0, 4'h0, 8'hFF, 32'h12345678, 1'b1, 1'b0, 4'h0, 8'hFF, 32'h12345678};
        vt[3] = '{1'b1, 4'h0, 8'h00, 32'hFFFFFFFF, 1'b1, 1'b1, 4'h0, 8'h00, 32'hFFFFFFFF};
        vt[4] = '{1'b1, 4'h1, 8'h7F, 32'h00000011, 1'b1, 1'b1, 4'h1, 8'h7F, 32'h00000011};
        vt[5] = '{1'b0, 4'hF, 8'h80, 32'hCAFEF00D, 1'b1, 1'b0, 4'hF, 8'h80, 32'hCAFEF00D};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst gnt", h_gnt_o, 1'b1);
        check("rst busy", busy_o, 1'b0);
        check("rst done", done_o, 1'b0);
        check("rst fail", fail_o, 1'b0);
        check("rst err", err_cnt_o, 0);
        check("rst fail_addr", fail_addr_o, 0);
        check("rst fail_exp", fail_exp_o, 0);
        check("rst fail_act", fail_act_o, 0);
        check("rst ram_ena", ram_ena_o, 1'b0);
        rst_n = 1'b1;

        // Host pass-through table
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            h_ena_i = vt[i].ena; h_wen_i = vt[i].wen; h_addr_i = vt[i].addr; h_wdata_i = vt[i].wdata;
            @(negedge clk);
            check($sformatf("pass vec%0d", i),
                  {h_gnt_o, ram_ena_o, ram_wen_o, ram_addr_o, ram_wdata_o},
                  {vt[i].exp_gnt, vt[i].exp_ena, vt[i].exp_wen, vt[i].exp_addr, vt[i].exp_wdata});
        end
        @(posedge clk); #1;
        h_ena_i = 1'b0; h_wen_i = '0; h_addr_i = '0; h_wdata_i = '0;
        check("host wr 0x10", mem[8'h10], 32'hDEADABEF);

        // Randomized pass-through while idle
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            h_ena_i = 1'($urandom); h_wen_i = 4'($urandom);
            h_addr_i = AW'($urandom); h_wdata_i = $urandom;
            want = {1'b1, h_ena_i, h_wen_i, h_addr_i, h_wdata_i};
            @(negedge clk);
            got = {h_gnt_o, ram_ena_o, ram_wen_o, ram_addr_o, ram_wdata_o};
            check($sformatf("pass rnd%0d", i), got, want);
        end
        @(posedge clk); #1;
        h_ena_i = 1'b0; h_wen_i = '0; h_addr_i = '0; h_wdata_i = '0;

        // Clean run, bg = 0
        do_start(32'h0, 1'b0);
        count_busy(0, 0, n);
        check_run("clean0", n, 11*D, 1'b1, 0, '0, '0, '0);

        // Clean run with alternating background, start pulse mid-run must be ignored
        do_start(32'hA5A5A5A5, 1'b0);
        count_busy(1000, 0, n);
        check_run("cleanA5", n, 11*D, 1'b1, 0, '0, '0, '0);

        // Stuck-at-1 on bit 5 at 0x3A
        fault_addr = 8'h3A; s1 = 32'h20; s0 = '0;
        do_start(32'h0, 1'b0);
        count_busy(0, 0, n);
        check_run("sa1_3A", n, 11*D, 1'b1, 3, 8'h3A, 32'h0, 32'h20);

        // abort in IDLE leaves status alone
        @(posedge clk); #1; abort_i = 1'b1;
        @(posedge clk); #1; abort_i = 1'b0;
        check("idle abort busy", busy_o, 1'b0);
        check("idle abort status", {done_o, fail_o, err_cnt_o}, {1'b1, 1'b1, 8'd3});

        // Randomized single stuck-bit faults against the reference
        for (int r = 0; r < 4; r++) begin
            int bitn;
            logic [31:0] bgr;
            bgr = $urandom;
            bitn = $urandom_range(0, 31);
            fault_addr = $urandom_range(0, D - 1);
            if ($urandom_range(0, 1) == 1) begin
                s1 = 32'h1 << bitn; s0 = '0;
            end else begin
                s1 = '0; s0 = 32'h1 << bitn;
            end
            ref_march(bgr, errs, faddr, fexp, fact);
            do_start(bgr, 1'b0);
            count_busy(0, 0, n);
            check_run($sformatf("rnd%0d", r), n, 11*D, 1'b1, errs, faddr, fexp, fact);
        end

        // Fault on every word: counter saturates
        fault_all = 1'b1; s1 = 32'h1; s0 = '0;
        ref_march(32'h0, errs, faddr, fexp, fact);
        do_start(32'h0, 1'b0);
        count_busy(0, 0, n);
        check_run("saturate", n, 11*D, 1'b1, errs, faddr, fexp, fact);
        check("saturate err max", err_cnt_o, 8'hFF);
        fault_all = 1'b0;

        // Abort on the compare cycle of the faulty address: compare dropped, write done
        fault_addr = 5; s1 = 32'h1; s0 = '0;
        do_start(32'h0, 1'b0);
        count_busy(0, 268, n);
        check_run("abort268", n, 268, 1'b0, 0, '0, '0, '0);
        check("abort268 write", mem[5], 32'hFFFFFFFF);

        // Abort at cycle 500 keeps accumulated error state
        do_start(32'h0, 1'b0);
        count_busy(0, 500, n);
        check_run("abort500", n, 500, 1'b0, 1, 8'h05, 32'h0, 32'h1);

        // start and abort together in IDLE: start wins, full run
        fault_addr = -1; s1 = '0;
        do_start(32'h0, 1'b1);
        count_busy(0, 0, n);
        check_run("start_abort", n, 11*D, 1'b1, 0, '0, '0, '0);

        // Asynchronous reset in the middle of M3
        fault_addr = 5; s1 = 32'h1;
        do_start(32'h0, 1'b0);
        repeat (1400) @(posedge clk);
        #3;
        check("pre-rst busy", busy_o, 1'b1);
        check("pre-rst fail", fail_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid rst busy", busy_o, 1'b0);
        check("mid rst gnt", h_gnt_o, 1'b1);
        check("mid rst status", {done_o, fail_o, err_cnt_o}, '0);
        check("mid rst fail_loc", {fail_addr_o, fail_exp_o, fail_act_o}, '0);
        check("mid rst ram_ena", ram_ena_o, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fault_addr = -1; s1 = '0;
        do_start(32'h0, 1'b0);
        count_busy(0, 0, n);
        check_run("post_rst", n, 11*D, 1'b1, 0, '0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
